// File: rtl/ring_router_pkg.sv
// Shared packet type and helpers for the ring router node.
// Pure type/constant package; no timing.
// No flow control of its own.
package RouterPkg;

    // Node address fields are sized for the largest supported ring.
    localparam int NODE_W    = 8;
    localparam int PAYLOAD_W = 32;

    typedef struct packed {
        logic [NODE_W-1:0]    src;
        logic [NODE_W-1:0]    dest;
        logic [31:0]          pid;
        logic [PAYLOAD_W-1:0] payload;
    } pkt_t;

    // Bits needed to address num_nodes ring positions (at least one).
    function automatic int node_id_w(input int num_nodes);
        return (num_nodes > 1) ? $clog2(num_nodes) : 1;
    endfunction

endpackage

// File: rtl/ring_router_fifo.sv
// Generic synchronous FIFO with combinational head read.
// Latency: write visible at head one cycle later, no bypass.
// Backpressure: full/empty registered from count; write-when-full and read-when-empty are ignored.
module ring_fifo
    import RouterPkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = pkt_t
) (
    input  logic clk,
    input  logic rst_l,
    input  T     data_in,
    input  logic we,
    input  logic re,
    output T     data_out,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T               mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           wr_en;
    logic           rd_en;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign wr_en    = we && !full;
    assign rd_en    = re && !empty;
    assign data_out = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= data_in;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ring_router.sv
// Ring node: forwards transit packets, ejects local ones, injects local traffic with starvation bound.
// Latency: ring_in->ring_out 1 cycle min, ring_in->ej_valid 1 cycle, inject->ring_out 1 cycle min.
// Backpressure: readies are registered FIFO not-full; ring_out selection locks while stalled.
module ring_router
    import RouterPkg::*;
#(
    parameter int NUM_NODES    = 8,
    parameter int NODE_ID      = 0,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_l,
    input  logic ring_in_valid,
    input  pkt_t ring_in,
    output logic ring_in_ready,
    output logic ring_out_valid,
    output pkt_t ring_out,
    input  logic ring_out_ready,
    input  logic inj_valid,
    input  pkt_t inj_pkt,
    output logic inj_ready,
    output logic ej_valid,
    output pkt_t ej_pkt,
    input  logic ej_ready,
    output logic err_drop
);

    localparam int                SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [NODE_W-1:0] MY_ID      = NODE_W'(NODE_ID);
    localparam logic [NODE_W:0]   NODE_LIM   = (NODE_W + 1)'(NUM_NODES);

    // FIFO status / heads
    logic t_full, t_empty, i_full, i_empty, e_full, e_empty;
    pkt_t t_head, i_head, e_head;
    logic t_we, t_re, i_we, i_re, e_we;

    // Arbiter state
    logic          lock_q, lock_d;
    logic          lock_sel_q, lock_sel_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          err_drop_q, err_drop_d;
    logic          sel_inj;

    logic ring_fire, ring_local;
    logic inj_fire, inj_bad;
    logic out_fire;

    // Ring ingress: only FIFO state gates ready, so no path from ring_in data.
    assign ring_in_ready = !t_full && !e_full;
    assign ring_fire     = ring_in_valid && ring_in_ready;
    assign ring_local    = (ring_in.dest == MY_ID);
    assign t_we          = ring_fire && !ring_local;
    assign e_we          = ring_fire && ring_local;

    // Injection: self-addressed or out-of-range destinations are accepted then discarded.
    assign inj_ready = !i_full;
    assign inj_fire  = inj_valid && inj_ready;
    assign inj_bad   = (inj_pkt.dest == MY_ID) || ({1'b0, inj_pkt.dest} >= NODE_LIM);
    assign i_we      = inj_fire && !inj_bad;

    // Ejection straight from the E head.
    assign ej_valid = !e_empty;
    assign ej_pkt   = e_head;

    // Egress
    assign ring_out_valid = !t_empty || !i_empty;
    assign ring_out       = sel_inj ? i_head : t_head;
    assign out_fire       = ring_out_valid && ring_out_ready;
    assign t_re           = out_fire && !sel_inj;
    assign i_re           = out_fire && sel_inj;
    assign err_drop       = err_drop_q;

    ring_fifo #(.DEPTH(DEPTH), .T(pkt_t)) u_t_fifo (
        .clk      (clk),
        .rst_l    (rst_l),
        .data_in  (ring_in),
        .we       (t_we),
        .re       (t_re),
        .data_out (t_head),
        .full     (t_full),
        .empty    (t_empty)
    );

    ring_fifo #(.DEPTH(DEPTH), .T(pkt_t)) u_i_fifo (
        .clk      (clk),
        .rst_l    (rst_l),
        .data_in  (inj_pkt),
        .we       (i_we),
        .re       (i_re),
        .data_out (i_head),
        .full     (i_full),
        .empty    (i_empty)
    );

    ring_fifo #(.DEPTH(DEPTH), .T(pkt_t)) u_e_fifo (
        .clk      (clk),
        .rst_l    (rst_l),
        .data_in  (ring_in),
        .we       (e_we),
        .re       (ej_ready),
        .data_out (e_head),
        .full     (e_full),
        .empty    (e_empty)
    );

    // Output selection: held while locked, else transit priority unless inject has starved.
    always_comb begin
        sel_inj = 1'b0;
        if (lock_q) begin
            sel_inj = lock_sel_q;
        end else if (!i_empty && (t_empty || (starve_cnt_q == STARVE_MAX))) begin
            sel_inj = 1'b1;
        end
    end

    // Next-state for lock, starvation counter and drop pulse.
    always_comb begin
        lock_d       = ring_out_valid && !ring_out_ready;
        lock_sel_d   = sel_inj;
        starve_cnt_d = starve_cnt_q;
        err_drop_d   = inj_fire && inj_bad;
        if (i_re || i_empty) begin
            starve_cnt_d = '0;
        end else if (t_re && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lock_q       <= 1'b0;
            lock_sel_q   <= 1'b0;
            starve_cnt_q <= '0;
            err_drop_q   <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_sel_q   <= lock_sel_d;
            starve_cnt_q <= starve_cnt_d;
            err_drop_q   <= err_drop_d;
        end
    end

endmodule

// File: tb/tb_ring_router.sv
// Directed bench for ring_router with NODE_ID=2, NUM_NODES=8, DEPTH=4, STARVE_LIMIT=4.
// Inputs driven 1ns after posedge, outputs sampled on negedge.
// Table-driven single-cycle vectors plus sequences for backpressure, starvation and reset.
module tb_ring_router;
    import RouterPkg::*;

    localparam int NN  = 8;
    localparam int NID = 2;
    localparam int DP  = 4;
    localparam int SL  = 4;

    logic clk = 1'b0;
    logic rst_l;
    logic ring_in_valid, ring_in_ready;
    pkt_t ring_in;
    logic ring_out_valid, ring_out_ready;
    pkt_t ring_out;
    logic inj_valid, inj_ready;
    pkt_t inj_pkt;
    logic ej_valid, ej_ready;
    pkt_t ej_pkt;
    logic err_drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ring_router #(.NUM_NODES(NN), .NODE_ID(NID), .DEPTH(DP), .STARVE_LIMIT(SL)) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .ring_in_valid  (ring_in_valid),
        .ring_in        (ring_in),
        .ring_in_ready  (ring_in_ready),
        .ring_out_valid (ring_out_valid),
        .ring_out       (ring_out),
        .ring_out_ready (ring_out_ready),
        .inj_valid      (inj_valid),
        .inj_pkt        (inj_pkt),
        .inj_ready      (inj_ready),
        .ej_valid       (ej_valid),
        .ej_pkt         (ej_pkt),
        .ej_ready       (ej_ready),
        .err_drop       (err_drop)
    );

    typedef struct {
        logic riv; int rdest; int rpid; logic ror;
        logic iv;  int idest; int ipid; logic ejr;
        logic x_rir; logic x_rov; int x_opid; logic x_ir;
        logic x_ejv; int x_ejpid; logic x_err;
    } vec_t;

    vec_t vq[$];

    function automatic pkt_t mk(input int dest, input int pid);
        pkt_t p;
        p         = '0;
        p.src     = NODE_W'(NID);
        p.dest    = NODE_W'(dest);
        p.pid     = 32'(pid);
        p.payload = 32'(pid * 3 + 1);
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic add(input logic riv, input int rdest, input int rpid, input logic ror,
                       input logic iv, input int idest, input int ipid, input logic ejr,
                       input logic x_rir, input logic x_rov, input int x_opid, input logic x_ir,
                       input logic x_ejv, input int x_ejpid, input logic x_err);
        vec_t v;
        v.riv = riv; v.rdest = rdest; v.rpid = rpid; v.ror = ror;
        v.iv = iv; v.idest = idest; v.ipid = ipid; v.ejr = ejr;
        v.x_rir = x_rir; v.x_rov = x_rov; v.x_opid = x_opid; v.x_ir = x_ir;
        v.x_ejv = x_ejv; v.x_ejpid = x_ejpid; v.x_err = x_err;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        ring_in_valid  = 1'b0;
        ring_in        = '0;
        ring_out_ready = 1'b1;
        inj_valid      = 1'b0;
        inj_pkt        = '0;
        ej_ready       = 1'b1;
    endtask

    initial begin
        int   expb [10];
        int   exp_q[$];
        logic pend;
        logic fire;

        rst_l = 1'b0;
        idle_inputs();

        //   riv rd rpid ror iv id ipid ejr | rir rov opid ir ejv ejpid err
        add(0, 0, 0, 1, 0, 0, 0,  0,  1, 0, 0,  1, 0, 0, 0); // reset state
        add(1, 2, 5, 1, 0, 0, 0,  0,  1, 0, 0,  1, 0, 0, 0); // local packet in
        add(0, 0, 0, 1, 0, 0, 0,  0,  1, 0, 0,  1, 1, 5, 0); // ejected, held
        add(0, 0, 0, 1, 0, 0, 0,  1,  1, 0, 0,  1, 1, 5, 0); // popped
        add(1, 4, 7, 1, 0, 0, 0,  1,  1, 0, 0,  1, 0, 0, 0); // transit in
        add(0, 0, 0, 1, 0, 0, 0,  1,  1, 1, 7,  1, 0, 0, 0); // transit out
        add(0, 0, 0, 1, 0, 0, 0,  1,  1, 0, 0,  1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 2, 20, 1,  1, 0, 0,  1, 0, 0, 0); // inject to self
        add(0, 0, 0, 1, 1, 8, 21, 1,  1, 0, 0,  1, 0, 0, 1); // inject out of range
        add(0, 0, 0, 1, 0, 0, 0,  1,  1, 0, 0,  1, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0,  1,  1, 0, 0,  1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 5, 30, 1,  1, 0, 0,  1, 0, 0, 0); // valid inject
        add(0, 0, 0, 1, 0, 0, 0,  1,  1, 1, 30, 1, 0, 0, 0); // out in 1 cycle
        add(0, 0, 0, 1, 0, 0, 0,  1,  1, 0, 0,  1, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1 rst_l = 1'b1;

        // ---- table-driven vectors ----
        foreach (vq[k]) begin
            @(posedge clk); #1;
            ring_in_valid  = vq[k].riv;
            ring_in        = vq[k].riv ? mk(vq[k].rdest, vq[k].rpid) : '0;
            ring_out_ready = vq[k].ror;
            inj_valid      = vq[k].iv;
            inj_pkt        = vq[k].iv ? mk(vq[k].idest, vq[k].ipid) : '0;
            ej_ready       = vq[k].ejr;
            @(negedge clk);
            chk($sformatf("v%0d.ring_in_ready", k), 32'(ring_in_ready), 32'(vq[k].x_rir));
            chk($sformatf("v%0d.ring_out_valid", k), 32'(ring_out_valid), 32'(vq[k].x_rov));
            chk($sformatf("v%0d.inj_ready", k), 32'(inj_ready), 32'(vq[k].x_ir));
            chk($sformatf("v%0d.ej_valid", k), 32'(ej_valid), 32'(vq[k].x_ejv));
            chk($sformatf("v%0d.err_drop", k), 32'(err_drop), 32'(vq[k].x_err));
            if (vq[k].x_rov) chk($sformatf("v%0d.ring_out.pid", k), ring_out.pid, 32'(vq[k].x_opid));
            if (vq[k].x_ejv) chk($sformatf("v%0d.ej_pkt.pid", k), ej_pkt.pid, 32'(vq[k].x_ejpid));
        end
        @(posedge clk); #1;
        idle_inputs();

        // ---- backpressure: fill T, ready falls, order preserved on release ----
        ring_out_ready = 1'b0;
        ring_in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ring_in = mk(4, 10 + k);
            @(negedge clk);
            chk($sformatf("bp.rir_%0d", k), 32'(ring_in_ready), 32'd1);
            @(posedge clk); #1;
        end
        ring_in = mk(4, 14);
        @(negedge clk);
        chk("bp.rir_full", 32'(ring_in_ready), 32'd0);
        chk("bp.rov_full", 32'(ring_out_valid), 32'd1);
        chk("bp.head", ring_out.pid, 32'd10);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp.rir_held", 32'(ring_in_ready), 32'd0);
        chk("bp.head_held", ring_out.pid, 32'd10);
        exp_q = '{10, 11, 12, 13, 14};
        pend  = 1'b1;
        for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
            @(posedge clk); #1;
            ring_out_ready = 1'b1;
            ring_in_valid  = pend;
            @(negedge clk);
            fire = ring_in_valid && ring_in_ready;
            if (ring_out_valid) chk("bp.order", ring_out.pid, 32'(exp_q.pop_front()));
            if (fire) pend = 1'b0;
        end
        chk("bp.drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("bp.empty_after", 32'(ring_out_valid), 32'd0);

        // ---- starvation: inject wins after exactly 4 transit transfers ----
        expb = '{-1, 100, 101, 102, 103, 104, 200, 105, 106, 107};
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            ring_out_ready = 1'b1;
            ring_in_valid  = (c < 8);
            ring_in        = (c < 8) ? mk(4, 100 + c) : '0;
            inj_valid      = (c == 1);
            inj_pkt        = (c == 1) ? mk(5, 200) : '0;
            @(negedge clk);
            chk($sformatf("st.rov_%0d", c), 32'(ring_out_valid), 32'(expb[c] >= 0));
            if (expb[c] >= 0) chk($sformatf("st.pid_%0d", c), ring_out.pid, 32'(expb[c]));
            if (c == 5) chk("st.cnt_before", 32'(dut.starve_cnt_q), 32'd3);
            if (c == 6) chk("st.cnt_limit", 32'(dut.starve_cnt_q), 32'(SL));
            if (c == 7) chk("st.cnt_cleared", 32'(dut.starve_cnt_q), 32'd0);
        end
        @(posedge clk); #1;
        idle_inputs();

        // ---- reset with buffered packets ----
        ring_out_ready = 1'b0;
        ej_ready       = 1'b0;
        for (int c = 0; c < 5; c++) begin
            ring_in_valid = 1'b1;
            ring_in       = (c == 0) ? mk(NID, 50) : mk(4, 50 + c);
            inj_valid     = (c < 4);
            inj_pkt       = mk(5, 60 + c);
            @(posedge clk); #1;
        end
        idle_inputs();
        ring_out_ready = 1'b0;
        ej_ready       = 1'b0;
        @(negedge clk);
        chk("rst.pre_rir", 32'(ring_in_ready), 32'd0);
        chk("rst.pre_ir", 32'(inj_ready), 32'd0);
        chk("rst.pre_rov", 32'(ring_out_valid), 32'd1);
        chk("rst.pre_ejv", 32'(ej_valid), 32'd1);
        #1 rst_l = 1'b0;
        #1;
        chk("rst.rov", 32'(ring_out_valid), 32'd0);
        chk("rst.ejv", 32'(ej_valid), 32'd0);
        chk("rst.ring_out", ring_out.pid, 32'd0);
        chk("rst.ej_pkt", ej_pkt.pid, 32'd0);
        chk("rst.err", 32'(err_drop), 32'd0);
        @(posedge clk); #1;
        rst_l = 1'b1;
        @(negedge clk);
        chk("rst.post_rir", 32'(ring_in_ready), 32'd1);
        chk("rst.post_ir", 32'(inj_ready), 32'd1);
        chk("rst.post_rov", 32'(ring_out_valid), 32'd0);
        chk("rst.post_ejv", 32'(ej_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
